// File: rtl/terminal_cmd_executor.sv
// rtl/terminal_cmd_executor.sv - runs parser commands against the text RAM: cursor, circular scroll, row clears
// Optional macro LINE_WRAP_EN: a printable at the last column wraps to column 0 and performs an IND.
module terminal_cmd_executor #(
  parameter int ROWS       = 24,
  parameter int COLS       = 80,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commandReady,
  input  logic [3:0]        commandType,
  input  logic [7:0]        Pn1,
  input  logic [7:0]        Pn2,
  input  logic [7:0]        Pchar,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [7:0]        ramData,
  output logic [7:0]        cursorRow,
  output logic [7:0]        cursorCol,
  output logic [7:0]        scrollTop,
  output logic              busy,
  output logic              overflow
);
  localparam logic [3:0] C_INPUT = 4'd0, C_IND = 4'd1, C_NEL = 4'd2, C_RI = 4'd3, C_CUU = 4'd4,
                         C_CUD = 4'd5, C_CUF = 4'd6, C_CUB = 4'd7, C_CUP = 4'd8;
  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [8:0] ROW_MAX = 9'(ROWS - 1);
  localparam logic [8:0] COL_MAX = 9'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;
  typedef struct packed {
    logic [3:0] typ;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] ch;
  } cmd_t;

  cmd_t              r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;
  state_t            r_state;
  cmd_t              r_cmd;
  logic [7:0]        r_row, r_col, r_st, r_clr_col;
  logic              r_we, r_ovf;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;

  cmd_t       w_in, w_head;
  logic       w_full, w_push, w_pop, w_head_print;
  logic [8:0] w_row, w_col, w_st, w_sum, w_phys, w_n1, w_p1, w_p2;
  logic [8:0] w_nrow, w_ncol, w_nst, w_clr_phys;
  logic       w_ind, w_ri, w_clr;
  logic [15:0] w_cur_lin, w_clr_lin;
  logic       w_unused;

  assign w_in   = {commandType, Pn1, Pn2, Pchar};
  assign w_head = r_fifo[r_rptr];
  assign w_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_push = commandReady && !w_full;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_print = (w_head.typ == C_INPUT) && (w_head.ch >= 8'h20) && (w_head.ch <= 8'h7E);

  assign w_row  = {1'b0, r_row};
  assign w_col  = {1'b0, r_col};
  assign w_st   = {1'b0, r_st};
  assign w_sum  = w_row + w_st;
  assign w_phys = (w_sum >= 9'(ROWS)) ? w_sum - 9'(ROWS) : w_sum;
  assign w_n1   = (r_cmd.p1 == 8'd0) ? 9'd1 : {1'b0, r_cmd.p1};
  assign w_p1   = {1'b0, r_cmd.p1};
  assign w_p2   = {1'b0, r_cmd.p2};
  assign w_cur_lin = 16'(w_phys) * 16'(COLS) + 16'(w_col);
  assign w_clr_lin = 16'(w_clr_phys) * 16'(COLS);

  // Effect of the registered command on cursor and scroll, evaluated in EXEC
  always_comb begin
    w_nrow = w_row;
    w_ncol = w_col;
    w_nst  = w_st;
    w_ind  = 1'b0;
    w_ri   = 1'b0;
    w_clr  = 1'b0;
    w_clr_phys = '0;
    case (r_cmd.typ)
      C_INPUT: begin
        if (r_cmd.ch >= 8'h20 && r_cmd.ch <= 8'h7E) begin
          if (w_col != COL_MAX) w_ncol = w_col + 9'd1;
`ifdef LINE_WRAP_EN
          else begin
            w_ncol = '0;
            w_ind  = 1'b1;
          end
`endif
        end else if (r_cmd.ch == 8'h0D) w_ncol = '0;
        else if (r_cmd.ch == 8'h0A) w_ind = 1'b1;
        else if (r_cmd.ch == 8'h08) w_ncol = (w_col == '0) ? '0 : w_col - 9'd1;
      end
      C_IND: w_ind = 1'b1;
      C_NEL: begin
        w_ind  = 1'b1;
        w_ncol = '0;
      end
      C_RI:  w_ri = 1'b1;
      C_CUU: w_nrow = (w_n1 > w_row) ? '0 : w_row - w_n1;
      C_CUD: w_nrow = (w_row + w_n1 > ROW_MAX) ? ROW_MAX : w_row + w_n1;
      C_CUF: w_ncol = (w_col + w_n1 > COL_MAX) ? COL_MAX : w_col + w_n1;
      C_CUB: w_ncol = (w_n1 > w_col) ? '0 : w_col - w_n1;
      C_CUP: begin
        w_nrow = (w_p1 == '0) ? '0 : (w_p1 > 9'(ROWS)) ? ROW_MAX : w_p1 - 9'd1;
        w_ncol = (w_p2 == '0) ? '0 : (w_p2 > 9'(COLS)) ? COL_MAX : w_p2 - 9'd1;
      end
      default: ;
    endcase
    if (w_ind) begin
      if (w_row != ROW_MAX) w_nrow = w_row + 9'd1;
      else begin
        w_nst = (w_st == ROW_MAX) ? '0 : w_st + 9'd1;
        w_clr = 1'b1;
        w_clr_phys = w_st;
      end
    end
    if (w_ri) begin
      if (w_row != '0) w_nrow = w_row - 9'd1;
      else begin
        w_nst = (w_st == '0) ? ROW_MAX : w_st - 9'd1;
        w_clr = 1'b1;
        w_clr_phys = w_nst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0; r_ovf <= 1'b0;
      r_state <= S_IDLE; r_cmd <= '0; r_clr_col <= '0;
      r_row <= '0; r_col <= '0; r_st <= '0;
      r_we <= 1'b0; r_addr <= '0; r_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (commandReady && w_full) r_ovf <= 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (w_pop) begin
            r_cmd   <= w_head;
            r_state <= S_EXEC;
            // Printable writes are issued on entry so they land in the EXEC cycle
            if (w_head_print) begin
              r_we   <= 1'b1;
              r_addr <= w_cur_lin[ADDR_W-1:0];
              r_data <= w_head.ch;
            end
          end
        end
        S_EXEC: begin
          r_we  <= 1'b0;
          r_row <= w_nrow[7:0];
          r_col <= w_ncol[7:0];
          r_st  <= w_nst[7:0];
          if (w_clr) begin
            r_state   <= S_CLEAR;
            r_clr_col <= '0;
            r_we      <= 1'b1;
            r_addr    <= w_clr_lin[ADDR_W-1:0];
            r_data    <= 8'h20;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (r_clr_col == COL_MAX[7:0]) begin
            r_we    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_clr_col <= r_clr_col + 8'd1;
            r_addr    <= r_addr + ADDR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ramWe     = r_we;
  assign ramAddr   = r_addr;
  assign ramData   = r_data;
  assign cursorRow = r_row;
  assign cursorCol = r_col;
  assign scrollTop = r_st;
  assign overflow  = r_ovf;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);

  assign w_unused = ^{w_nrow[8], w_ncol[8], w_nst[8], w_cur_lin, w_clr_lin};
endmodule

// File: tb/tb_terminal_cmd_executor.sv
// tb/tb_terminal_cmd_executor.sv - randomized and directed checks of terminal_cmd_executor against a screen-level model
module tb_terminal_cmd_executor;
  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int AW   = 11;
  localparam int T_INPUT = 0, T_IND = 1, T_NEL = 2, T_RI = 3, T_CUU = 4,
                 T_CUD = 5, T_CUF = 6, T_CUB = 7, T_CUP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          commandReady = 1'b0;
  logic [3:0]    commandType = '0;
  logic [7:0]    Pn1 = '0, Pn2 = '0, Pchar = '0;
  logic          ramWe, busy, overflow;
  logic [AW-1:0] ramAddr;
  logic [7:0]    ramData, cursorRow, cursorCol, scrollTop;

  terminal_cmd_executor #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst_n), .commandReady(commandReady), .commandType(commandType),
    .Pn1(Pn1), .Pn2(Pn2), .Pchar(Pchar), .ramWe(ramWe), .ramAddr(ramAddr), .ramData(ramData),
    .cursorRow(cursorRow), .cursorCol(cursorCol), .scrollTop(scrollTop), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int m_row, m_col, m_st;
  int m_ovf;
  int exp_addr[$];
  int exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Screen-level model: cursor, scroll offset and the list of RAM writes still owed
  task automatic clear_row(input int p);
    for (int c = 0; c < COLS; c++) begin
      exp_addr.push_back(p * COLS + c);
      exp_data.push_back(32'h20);
    end
  endtask

  task automatic m_ind();
    if (m_row < ROWS - 1) m_row++;
    else begin
      m_st = (m_st + 1) % ROWS;
      clear_row((ROWS - 1 + m_st) % ROWS);
    end
  endtask

  task automatic m_ri();
    if (m_row > 0) m_row--;
    else begin
      m_st = (m_st + ROWS - 1) % ROWS;
      clear_row(m_st);
    end
  endtask

  task automatic model(input int t, input int p1, input int p2, input int ch);
    int n;
    n = (p1 == 0) ? 1 : p1;
    case (t)
      T_INPUT: begin
        if (ch >= 32 && ch <= 126) begin
          exp_addr.push_back(((m_row + m_st) % ROWS) * COLS + m_col);
          exp_data.push_back(ch);
          if (m_col < COLS - 1) m_col++;
          else begin
`ifdef LINE_WRAP_EN
            m_col = 0;
            m_ind();
`endif
          end
        end else if (ch == 13) m_col = 0;
        else if (ch == 10) m_ind();
        else if (ch == 8) m_col = (m_col > 0) ? m_col - 1 : 0;
      end
      T_IND: m_ind();
      T_NEL: begin m_ind(); m_col = 0; end
      T_RI:  m_ri();
      T_CUU: m_row = (m_row - n < 0) ? 0 : m_row - n;
      T_CUD: m_row = (m_row + n > ROWS - 1) ? ROWS - 1 : m_row + n;
      T_CUF: m_col = (m_col + n > COLS - 1) ? COLS - 1 : m_col + n;
      T_CUB: m_col = (m_col - n < 0) ? 0 : m_col - n;
      T_CUP: begin
        m_row = ((p1 < 1) ? 1 : (p1 > ROWS) ? ROWS : p1) - 1;
        m_col = ((p2 < 1) ? 1 : (p2 > COLS) ? COLS : p2) - 1;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n && ramWe) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d with no write owed", ramAddr, ramData);
      end else begin
        chk("wr_addr", ramAddr, exp_addr.pop_front());
        chk("wr_data", ramData, exp_data.pop_front());
        chk("busy_on_write", busy, 1);
      end
    end
  end

  task automatic send(input int t, input int p1, input int p2, input int ch, input bit accept = 1'b1);
    commandType = t[3:0];
    Pn1 = p1[7:0];
    Pn2 = p2[7:0];
    Pchar = ch[7:0];
    commandReady = 1'b1;
    @(posedge clk);
    #1;
    commandReady = 1'b0;
    if (accept) model(t, p1, p2, ch);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: busy got 1 expected 0 within 1000 cycles", tag);
    end
  endtask

  task automatic wait_we(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (ramWe) break;
      @(posedge clk);
      #1;
    end
    if (!ramWe) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: ramWe got 0 expected 1 within 10 cycles", tag);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_row"}, cursorRow, m_row);
    chk({tag, "_col"}, cursorCol, m_col);
    chk({tag, "_scroll"}, scrollTop, m_st);
    chk({tag, "_overflow"}, overflow, m_ovf);
    chk({tag, "_writes_owed"}, exp_addr.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    commandReady = 1'b0;
    #1;
    m_row = 0; m_col = 0; m_st = 0; m_ovf = 0;
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_we", ramWe, 0);
    chk("rst_addr", ramAddr, 0);
    chk("rst_data", ramData, 0);
    chk("rst_row", cursorRow, 0);
    chk("rst_col", cursorCol, 0);
    chk("rst_scroll", scrollTop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  task automatic rand_cmd();
    int t, p1, p2, ch;
    t = $urandom_range(0, 8);
    if ($urandom_range(0, 1) == 1) t = T_INPUT;
    case ($urandom_range(0, 5))
      0: ch = 13;
      1: ch = 10;
      2: ch = 8;
      3: ch = $urandom_range(0, 255);
      default: ch = $urandom_range(32, 126);
    endcase
    case ($urandom_range(0, 4))
      0: p1 = 0;
      1: p1 = 1;
      2: p1 = $urandom_range(2, 30);
      3: p1 = $urandom_range(0, 255);
      default: p1 = 200;
    endcase
    p2 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 90) : $urandom_range(0, 255);
    send(t, p1, p2, ch);
  endtask

  initial begin
    do_reset();

    // Latency of a single printable from an empty FIFO
    commandType = T_INPUT[3:0];
    Pchar = 8'h41;
    commandReady = 1'b1;
    @(posedge clk);
    #1;
    commandReady = 1'b0;
    model(T_INPUT, 0, 0, 8'h41);
    chk("lat_cycle1_we", ramWe, 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_we", ramWe, 1);
    chk("lat_addr", ramAddr, 0);
    chk("lat_data", ramData, 8'h41);
    wait_idle("input_a");
    chk("input_a_col", cursorCol, 1);
    check_state("input_a");

    send(T_CUP, 5, 10, 0);
    wait_idle("cup");
    chk("cup_row", cursorRow, 4);
    chk("cup_col", cursorCol, 9);
    send(T_CUU, 0, 0, 0);
    wait_idle("cuu0");
    chk("cuu0_row", cursorRow, 3);
    send(T_CUP, 200, 0, 0);
    wait_idle("cup_clamp");
    chk("cup_clamp_row", cursorRow, 23);
    chk("cup_clamp_col", cursorCol, 0);
    check_state("cursor");

    send(T_IND, 0, 0, 0);
    wait_we("ind_clear");
    chk("ind_first_clear_addr", ramAddr, 0);
    wait_idle("ind");
    chk("ind_scroll", scrollTop, 1);
    check_state("ind");

    do_reset();
    send(T_RI, 0, 0, 0);
    wait_we("ri_clear");
    chk("ri_first_clear_addr", ramAddr, 1840);
    wait_idle("ri");
    chk("ri_scroll", scrollTop, 23);
    check_state("ri");

    // Six pushes during a clear: four fit, two are dropped
    do_reset();
    send(T_CUP, 24, 1, 0);
    wait_idle("ovf_setup");
    send(T_IND, 0, 0, 0);
    wait_we("ovf_clear");
    for (int i = 0; i < 6; i++) send(T_INPUT, 0, 0, 8'h61 + i, i < 4);
    m_ovf = 1;
    chk("ovf_flag", overflow, 1);
    wait_idle("ovf");
    chk("ovf_col", cursorCol, 4);
    check_state("ovf");

    // Reset in the middle of a clear abandons it
    send(T_IND, 0, 0, 0);
    wait_we("abandon_clear");
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("abandon_we", ramWe, 0);
    chk("abandon_busy", busy, 0);

    send(T_CUP, 24, 80, 0);
    wait_idle("wrap_setup");
    send(T_INPUT, 0, 0, 8'h5A);
    wait_we("wrap_write");
    chk("wrap_addr", ramAddr, 1919);
    chk("wrap_data", ramData, 8'h5A);
    wait_idle("wrap");
`ifdef LINE_WRAP_EN
    chk("wrap_col", cursorCol, 0);
    chk("wrap_scroll", scrollTop, 1);
`else
    chk("wrap_col", cursorCol, 79);
    chk("wrap_scroll", scrollTop, 0);
`endif
    check_state("wrap");
    send(T_INPUT, 0, 0, 8'h59);
    wait_idle("wrap2");
    check_state("wrap2");

    do_reset();
    for (int it = 0; it < 100; it++) begin
      int burst;
      burst = $urandom_range(1, 4);
      for (int k = 0; k < burst; k++) rand_cmd();
      wait_idle("rand");
      check_state("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
